// File: rtl/servo_ramp_ctrl.sv
// Single-servo PWM generator with clamped, rate-limited position commands.
// Each accepted target is approached by at most STEP ticks per frame, then held for HOLD_FRAMES frames.
module servo_ramp_ctrl #(
    parameter int FRAME_TICKS = 1000,
    parameter int MIN_PULSE   = 25,
    parameter int MAX_PULSE   = 125,
    parameter int INIT_PULSE  = 35,
    parameter int STEP        = 2,
    parameter int HOLD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_pulse,
    output logic        cmd_ready,
    output logic        servo,
    output logic [15:0] cur_pulse,
    output logic        busy,
    output logic        frame_end
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int         HOLD_LAST    = (HOLD_FRAMES > 0) ? (HOLD_FRAMES - 1) : 0;
    localparam logic [15:0] P_FRAME_LAST = 16'(FRAME_TICKS - 1);
    localparam logic [15:0] P_MIN        = 16'(MIN_PULSE);
    localparam logic [15:0] P_MAX        = 16'(MAX_PULSE);
    localparam logic [15:0] P_INIT       = 16'(INIT_PULSE);
    localparam logic [15:0] P_STEP       = 16'(STEP);
    localparam logic [15:0] P_HOLD_LAST  = 16'(HOLD_LAST);

    // Unsigned saturation of a raw command into the safe pulse range.
    function automatic logic [15:0] clamp_pulse(input logic [15:0] p);
        logic [15:0] res;
        if (p < P_MIN) begin
            res = P_MIN;
        end else if (p > P_MAX) begin
            res = P_MAX;
        end else begin
            res = p;
        end
        return res;
    endfunction

    // Compare first, then subtract the smaller from the larger, so the difference never wraps.
    function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] res;
        if (tgt > cur) begin
            if ((tgt - cur) > P_STEP) begin
                res = cur + P_STEP;
            end else begin
                res = tgt;
            end
        end else begin
            if ((cur - tgt) > P_STEP) begin
                res = cur - P_STEP;
            end else begin
                res = tgt;
            end
        end
        return res;
    endfunction

    logic [15:0] r_cnt;
    logic [1:0]  r_state;
    logic [15:0] r_cur_pulse;
    logic [15:0] r_target;
    logic [15:0] r_hold_cnt;
    logic        r_servo;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_frame_end;

    logic [15:0] w_cnt_nxt;
    logic [1:0]  w_state_nxt;
    logic [15:0] w_pulse_nxt;
    logic [15:0] w_target_nxt;
    logic [15:0] w_hold_nxt;
    logic [15:0] w_cmd_clamped;
    logic [15:0] w_step_pulse;
    logic        w_accept;

    assign w_cmd_clamped = clamp_pulse(cmd_pulse);
    assign w_step_pulse  = step_toward(r_cur_pulse, r_target);
    assign w_accept      = cmd_valid && r_cmd_ready;

    // Free-running frame counter, wraps at the end of every frame.
    always_comb begin
        if (r_cnt == P_FRAME_LAST) begin
            w_cnt_nxt = 16'd0;
        end else begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    // Sequencer next-state: accept in IDLE, step on frame ends in RAMP, count frame ends in HOLD.
    always_comb begin
        w_state_nxt  = r_state;
        w_pulse_nxt  = r_cur_pulse;
        w_target_nxt = r_target;
        w_hold_nxt   = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_target_nxt = w_cmd_clamped;
                    w_hold_nxt   = 16'd0;
                    if (w_cmd_clamped != r_cur_pulse) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (r_frame_end) begin
                    w_pulse_nxt = w_step_pulse;
                    w_hold_nxt  = 16'd0;
                    if (w_step_pulse == r_target) begin
                        if (HOLD_FRAMES == 0) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_state_nxt = ST_RAMP;
                    end
                end else begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_HOLD: begin
                if (r_frame_end) begin
                    if (r_hold_cnt >= P_HOLD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = 16'd0;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = r_hold_cnt + 16'd1;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                // Illegal encoding: fall back to IDLE, keep the live width, drop the target.
                w_state_nxt  = ST_IDLE;
                w_target_nxt = r_cur_pulse;
                w_hold_nxt   = 16'd0;
            end
        endcase
    end

    // State, pulse and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 16'd0;
            r_state     <= ST_IDLE;
            r_cur_pulse <= P_INIT;
            r_target    <= P_INIT;
            r_hold_cnt  <= 16'd0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_state     <= w_state_nxt;
            r_cur_pulse <= w_pulse_nxt;
            r_target    <= w_target_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    // Registered outputs; status flags are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_servo     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_servo     <= (r_cnt < r_cur_pulse);
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_frame_end <= (w_cnt_nxt == P_FRAME_LAST);
        end
    end

    assign servo     = r_servo;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign frame_end = r_frame_end;
    assign cur_pulse = r_cur_pulse;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl: scenario tasks checked against a frame-level ramp model.
module tb_servo_ramp_ctrl;

    localparam int F     = 200;
    localparam int MINP  = 25;
    localparam int MAXP  = 125;
    localparam int INITP = 35;
    localparam int STEPP = 2;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_pulse = 16'd0;
    logic        cmd_ready;
    logic        servo;
    logic [15:0] cur_pulse;
    logic        busy;
    logic        frame_end;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pulse = INITP;

    always #10 clk = ~clk;

    servo_ramp_ctrl #(
        .FRAME_TICKS(F), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
        .INIT_PULSE(INITP), .STEP(STEPP), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_pulse(cmd_pulse),
        .cmd_ready(cmd_ready), .servo(servo), .cur_pulse(cur_pulse),
        .busy(busy), .frame_end(frame_end)
    );

    function automatic int clamp_ref(input int v);
        if (v < MINP) return MINP;
        if (v > MAXP) return MAXP;
        return v;
    endfunction

    // Per-frame widths seen while moving from 'from' to 'to' (empty when already there).
    function automatic void build_seq(input int from, input int to, output int q[$]);
        int w;
        q = {};
        w = from;
        while (w != to) begin
            if (to > w) w = (to - w > STEPP) ? w + STEPP : to;
            else        w = (w - to > STEPP) ? w - STEPP : to;
            q.push_back(w);
        end
    endfunction

    task automatic wait_fe();
        int k = 0;
        while (frame_end !== 1'b1 && k < F + 5) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (frame_end !== 1'b1) $display("FAIL wait_fe: frame_end=%b required 1 within %0d cycles", frame_end, F + 5);
        else n_pass++;
    endtask

    task automatic measure(output int hi);
        hi = 0;
        wait_fe();
        @(posedge clk); #1;
        for (int i = 0; i < F; i++) begin
            @(posedge clk); #1;
            if (servo === 1'b1) hi++;
        end
    endtask

    task automatic send(input logic [15:0] v);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_pulse = v;
        while (cmd_ready !== 1'b1 && k < 60 * F) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic follow(input int tgt);
        int q[$];
        int total;
        build_seq(exp_pulse, tgt, q);
        total = (q.size() > 0) ? q.size() + HOLD : 0;
        for (int i = 0; i < total; i++) begin
            wait_fe();
            @(posedge clk); #1;
            exp_pulse = (i < q.size()) ? q[i] : tgt;
            n_checks++;
            if (cur_pulse !== 16'(exp_pulse))
                $display("FAIL follow_pulse: frame %0d cur_pulse=%0d required %0d", i, cur_pulse, exp_pulse);
            else n_pass++;
            n_checks++;
            if (busy !== (i < total - 1) || cmd_ready !== (i == total - 1))
                $display("FAIL follow_flags: frame %0d busy=%b ready=%b required busy=%b ready=%b",
                         i, busy, cmd_ready, (i < total - 1), (i == total - 1));
            else n_pass++;
        end
    endtask

    task automatic command(input logic [15:0] v);
        int t;
        t = clamp_ref(int'(v));
        send(v);
        n_checks++;
        if (busy !== (t != exp_pulse))
            $display("FAIL accept_busy: cmd=%0d busy=%b required %b", v, busy, (t != exp_pulse));
        else n_pass++;
        if (t == exp_pulse) begin
            wait_fe();
            @(posedge clk); #1;
            n_checks++;
            if (cur_pulse !== 16'(exp_pulse) || busy !== 1'b0)
                $display("FAIL same_target: cur_pulse=%0d busy=%b required %0d 0", cur_pulse, busy, exp_pulse);
            else n_pass++;
        end else begin
            follow(t);
        end
    endtask

    task automatic test_reset();
        int hi;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cur_pulse !== 16'(INITP) || cmd_ready !== 1'b1 || busy !== 1'b0 || servo !== 1'b0 || frame_end !== 1'b0)
            $display("FAIL reset_state: cur=%0d ready=%b busy=%b servo=%b fe=%b required 35 1 0 0 0",
                     cur_pulse, cmd_ready, busy, servo, frame_end);
        else n_pass++;
        rst = 1'b0;
        exp_pulse = INITP;
        for (int f = 0; f < 3; f++) begin
            measure(hi);
            n_checks++;
            if (hi != INITP) $display("FAIL idle_pwm: frame %0d high=%0d required %0d", f, hi, INITP);
            else n_pass++;
        end
    endtask

    task automatic test_ramp_up();
        wait_fe();
        repeat (F / 2) @(posedge clk);
        #1;
        command(16'd45);
    endtask

    task automatic test_clamp();
        int hi;
        command(16'hFFFF);
        measure(hi);
        n_checks++;
        if (hi != MAXP) $display("FAIL clamp_max_pwm: high=%0d required %0d", hi, MAXP);
        else n_pass++;
        command(16'd3);
        measure(hi);
        n_checks++;
        if (hi != MINP) $display("FAIL clamp_min_pwm: high=%0d required %0d", hi, MINP);
        else n_pass++;
        command(16'd0);
        command(16'd35);
    endtask

    task automatic test_partial_step();
        command(16'd36);
        command(16'd36);
    endtask

    task automatic test_back_to_back();
        send(16'd45);
        cmd_valid = 1'b1;
        cmd_pulse = 16'd41;
        follow(45);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL pending_accept: busy=%b ready=%b required 1 0", busy, cmd_ready);
        else n_pass++;
        cmd_valid = 1'b0;
        follow(41);
    endtask

    task automatic test_reset_mid_ramp();
        int q[$];
        int hi;
        command(16'd35);
        build_seq(35, 45, q);
        send(16'd45);
        for (int i = 0; i < 3; i++) begin
            wait_fe();
            @(posedge clk); #1;
            n_checks++;
            if (cur_pulse !== 16'(q[i])) $display("FAIL pre_reset_ramp: cur_pulse=%0d required %0d", cur_pulse, q[i]);
            else n_pass++;
        end
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cur_pulse !== 16'(INITP) || busy !== 1'b0 || cmd_ready !== 1'b1 || servo !== 1'b0)
            $display("FAIL mid_ramp_reset: cur=%0d busy=%b ready=%b servo=%b required 35 0 1 0",
                     cur_pulse, busy, cmd_ready, servo);
        else n_pass++;
        rst = 1'b0;
        exp_pulse = INITP;
        measure(hi);
        n_checks++;
        if (hi != INITP) $display("FAIL post_reset_pwm: high=%0d required %0d", hi, INITP);
        else n_pass++;
        command(16'd35);
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 6; n++) begin
            r = exp_pulse + int'($urandom_range(0, 40)) - 20;
            if (r < 0) r = 0;
            command(16'(r));
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_partial_step();
        test_back_to_back();
        test_reset_mid_ramp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
